// File: rtl/mul_arb_pkg.sv
// Shared types and constants for the two-requester multiplier arbiter.
package mul_arb_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 64;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    WAIT  = 3'd2,
    DONE  = 3'd3,
    CLEAR = 3'd4
  } arb_state_e;

  // Watchdog counter width; at least one bit for tiny timeouts.
  function automatic int unsigned cnt_width(input int unsigned timeout);
    return (timeout > 2) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/mul_arbiter_if.sv
// Requester-side and multiplier-side signals of the arbiter, bundled as one interface.
interface mul_arbiter_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  req0, req1;
  logic [DATA_W-1:0]     a0, a1, b0, b1;
  logic                  gnt0, gnt1;
  logic                  done0, done1;
  logic [2*DATA_W-1:0]   result0, result1;
  logic                  err_timeout;
  logic [DATA_W-1:0]     mul_a, mul_b;
  logic                  mul_op_start, mul_op_clear;
  logic                  mul_op_done;
  logic [2*DATA_W-1:0]   mul_result;

  // Arbiter side.
  modport slave (
    input  req0, req1, a0, a1, b0, b1, mul_op_done, mul_result,
    output gnt0, gnt1, done0, done1, result0, result1, err_timeout,
           mul_a, mul_b, mul_op_start, mul_op_clear
  );

  // Requesters and multiplier side.
  modport master (
    output req0, req1, a0, a1, b0, b1, mul_op_done, mul_result,
    input  gnt0, gnt1, done0, done1, result0, result1, err_timeout,
           mul_a, mul_b, mul_op_start, mul_op_clear
  );
endinterface

// File: rtl/mul_arb_rr.sv
// Two-way round-robin picker: on a tie the requester not granted last time wins.
module mul_arb_rr (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_gnt_i,
  output logic pick_c,
  output logic any_c
);

  assign any_c  = req0_i | req1_i;
  assign pick_c = (req0_i & req1_i) ? ~last_gnt_i : req1_i;

endmodule

// File: rtl/mul_arbiter.sv
// Shares one sequential multiplier between two requesters: arbitration, op_start/op_clear
// sequencing, result return and a watchdog on the wait for op_done.
module mul_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          reset_n,
  mul_arbiter_if.slave bus
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = cnt_width(TIMEOUT);

  arb_state_e          state_q, state_d;
  logic                last_q, last_d;      // index of the current / most recent winner
  logic                gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic                done0_q, done0_d, done1_q, done1_d;
  logic                err_q, err_d;
  logic                start_q, start_d, clear_q, clear_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]   res0_q, res0_d, res1_q, res1_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic pick_c, any_c, req_win_c;

  mul_arb_rr u_rr (
    .req0_i     (bus.req0),
    .req1_i     (bus.req1),
    .last_gnt_i (last_q),
    .pick_c     (pick_c),
    .any_c      (any_c)
  );

  assign req_win_c = last_q ? bus.req1 : bus.req0;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    a_d     = a_q;
    b_d     = b_q;
    res0_d  = res0_q;
    res1_d  = res1_q;
    cnt_d   = cnt_q;
    done0_d = 1'b0;
    done1_d = 1'b0;
    err_d   = 1'b0;
    start_d = 1'b0;
    clear_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (any_c) begin
          last_d  = pick_c;
          gnt0_d  = ~pick_c;
          gnt1_d  = pick_c;
          a_d     = pick_c ? bus.a1 : bus.a0;
          b_d     = pick_c ? bus.b1 : bus.b0;
          start_d = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // Abort beats completion, completion beats the watchdog.
        if (!req_win_c) begin
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          clear_d = 1'b1;
          state_d = CLEAR;
        end else if (bus.mul_op_done) begin
          if (last_q) begin
            res1_d  = bus.mul_result;
            done1_d = 1'b1;
          end else begin
            res0_d  = bus.mul_result;
            done0_d = 1'b1;
          end
          state_d = DONE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          clear_d = 1'b1;
          state_d = CLEAR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        clear_d = 1'b1;
        state_d = CLEAR;
      end
      CLEAR: begin
        state_d = IDLE;
      end
      default: begin
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      clear_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res0_q  <= '0;
      res1_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      err_q   <= err_d;
      start_q <= start_d;
      clear_q <= clear_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.gnt0         = gnt0_q;
  assign bus.gnt1         = gnt1_q;
  assign bus.done0        = done0_q;
  assign bus.done1        = done1_q;
  assign bus.result0      = res0_q;
  assign bus.result1      = res1_q;
  assign bus.err_timeout  = err_q;
  assign bus.mul_a        = a_q;
  assign bus.mul_b        = b_q;
  assign bus.mul_op_start = start_q;
  assign bus.mul_op_clear = clear_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter: behavioural multiplier, scoreboard of expected products, scenario tasks.
module tb_mul_arbiter;

  typedef struct packed {
    logic        id;
    logic [63:0] prod;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mul_arbiter_if #(.DATA_W(32)) bus ();

  mul_arbiter #(.DATA_W(32), .TIMEOUT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  int   lat = 3;
  bit   never_done = 1'b0;

  // Multiplier model: op_done after lat cycles, held until op_clear.
  logic               m_busy;
  int                 m_cnt;
  logic signed [63:0] m_prod;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mul_op_done <= 1'b0;
      bus.mul_result  <= '0;
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_prod <= '0;
    end else if (bus.mul_op_clear) begin
      bus.mul_op_done <= 1'b0;
      m_busy <= 1'b0;
    end else if (bus.mul_op_start) begin
      m_busy <= 1'b1;
      m_cnt  <= lat;
      m_prod <= $signed({{32{bus.mul_a[31]}}, bus.mul_a}) * $signed({{32{bus.mul_b[31]}}, bus.mul_b});
    end else if (m_busy && !bus.mul_op_done && !never_done) begin
      if (m_cnt <= 1) begin
        bus.mul_op_done <= 1'b1;
        bus.mul_result  <= m_prod;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Invariants and scoreboard, checked on the falling edge.
  always @(negedge clk) begin
    if (reset_n) begin
      n_tests = n_tests + 1;
      if ((bus.gnt0 & bus.gnt1) | (bus.mul_op_start & bus.mul_op_clear)) begin
        n_fail = n_fail + 1;
        $display("FAIL invariant: gnt=%b%b start=%b clear=%b", bus.gnt1, bus.gnt0,
                 bus.mul_op_start, bus.mul_op_clear);
      end
      if (bus.done0 | bus.done1) begin
        n_tests = n_tests + 1;
        if (sb.size() == 0) begin
          n_fail = n_fail + 1;
          $display("FAIL sb_unexpected: done=%b%b with empty scoreboard", bus.done1, bus.done0);
        end else begin
          exp_t e;
          exp_t got;
          e = sb.pop_front();
          got.id   = bus.done1;
          got.prod = bus.done1 ? bus.result1 : bus.result0;
          if ((bus.done0 & bus.done1) || got !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL sb_result: got id=%0d prod=%h want id=%0d prod=%h", got.id, got.prod,
                     e.id, e.prod);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input bit who, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      step();
      if (who ? bus.done1 : bus.done0) ok = 1'b1;
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40 && !ok; k++) begin
      step();
      if (bus.mul_op_start) ok = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [327:0] outs;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
    repeat (2) @(posedge clk);
    #1;
    outs = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err_timeout, bus.mul_op_start,
            bus.mul_op_clear, bus.mul_a, bus.mul_b, bus.result0, bus.result1};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    reset_n = 1'b1;
    step();
    n_tests++;
    if ({bus.gnt0, bus.gnt1, bus.mul_op_start} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_idle: got gnt0/gnt1/start=%b want 000", {bus.gnt0, bus.gnt1, bus.mul_op_start});
    end
  endtask

  task automatic test_single();
    int  cyc = 0, opd_at = -1, done_at = -1;
    bit  gnt1_seen = 1'b0;
    do_reset();
    lat = 3;
    bus.a0 = 32'd7; bus.b0 = 32'hFFFF_FFFD; bus.req0 = 1'b1;
    sb.push_back('{id: 1'b0, prod: 64'hFFFF_FFFF_FFFF_FFEB});
    step();
    n_tests++;
    if ({bus.gnt0, bus.gnt1, bus.mul_op_start} !== 3'b101) begin
      n_fail++;
      $display("FAIL single_grant: got gnt0/gnt1/start=%b want 101", {bus.gnt0, bus.gnt1, bus.mul_op_start});
    end
    for (int k = 0; k < 40 && done_at < 0; k++) begin
      step();
      cyc++;
      if (bus.gnt1) gnt1_seen = 1'b1;
      if (bus.mul_op_done && opd_at < 0) opd_at = cyc;
      if (bus.done0) done_at = cyc;
    end
    n_tests++;
    if (done_at < 0 || done_at != opd_at + 1 || bus.result0 !== 64'hFFFF_FFFF_FFFF_FFEB
        || bus.mul_op_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: got done_at=%0d opdone_at=%0d result0=%h clear=%b want done one cycle after op_done, result ffffffffffffffeb",
               done_at, opd_at, bus.result0, bus.mul_op_clear);
    end
    bus.req0 = 1'b0;
    step();
    n_tests++;
    if ({bus.mul_op_clear, bus.gnt0, gnt1_seen} !== 3'b100) begin
      n_fail++;
      $display("FAIL single_clear: got clear/gnt0/gnt1_seen=%b want 100", {bus.mul_op_clear, bus.gnt0, gnt1_seen});
    end
    step();
    n_tests++;
    if (bus.mul_op_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL single_clear_pulse: got clear=%b want 0", bus.mul_op_clear);
    end
  endtask

  task automatic test_tie_after_reset();
    bit ok;
    do_reset();
    bus.a0 = 32'd5; bus.b0 = 32'd6; bus.a1 = 32'd9; bus.b1 = 32'd9;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    sb.push_back('{id: 1'b0, prod: 64'd30});
    sb.push_back('{id: 1'b1, prod: 64'd81});
    step();
    n_tests++;
    if ({bus.gnt0, bus.gnt1} !== 2'b10) begin
      n_fail++;
      $display("FAIL tie_first: got gnt0/gnt1=%b want 10", {bus.gnt0, bus.gnt1});
    end
    wait_done(1'b0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL tie_done0: got no done0 within 40 cycles want done0");
    end
    bus.req0 = 1'b0;
    step();
    step();
    n_tests++;
    if ({bus.mul_op_start, bus.gnt0, bus.gnt1} !== 3'b000) begin
      n_fail++;
      $display("FAIL tie_idle_gap: got start/gnt0/gnt1=%b want 000", {bus.mul_op_start, bus.gnt0, bus.gnt1});
    end
    step();
    n_tests++;
    if ({bus.mul_op_start, bus.gnt0, bus.gnt1} !== 3'b101) begin
      n_fail++;
      $display("FAIL tie_second: got start/gnt0/gnt1=%b want 101", {bus.mul_op_start, bus.gnt0, bus.gnt1});
    end
    wait_done(1'b1, ok);
    n_tests++;
    if (!ok || bus.result1 !== 64'd81) begin
      n_fail++;
      $display("FAIL tie_done1: got ok=%0d result1=%0d want 1 81", ok, bus.result1);
    end
    bus.req1 = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_back_to_back();
    bit ok;
    bit order[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    bus.a0 = 32'd2; bus.b0 = 32'd3; bus.a1 = 32'd4; bus.b1 = 32'd5;
    sb.push_back('{id: 1'b0, prod: 64'd6});
    sb.push_back('{id: 1'b1, prod: 64'd20});
    sb.push_back('{id: 1'b0, prod: 64'd42});
    sb.push_back('{id: 1'b1, prod: 64'd72});
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    for (int j = 0; j < 4; j++) begin
      wait_start(ok);
      n_tests++;
      if (!ok || {bus.gnt1, bus.gnt0} !== (order[j] ? 2'b10 : 2'b01)) begin
        n_fail++;
        $display("FAIL b2b_grant%0d: got ok=%0d gnt1/gnt0=%b want M%0d", j, ok, {bus.gnt1, bus.gnt0}, order[j]);
      end
      wait_done(order[j], ok);
      n_tests++;
      if (!ok) begin
        n_fail++;
        $display("FAIL b2b_done%0d: got no done within 40 cycles want done from M%0d", j, order[j]);
      end
      if (j == 0) begin bus.a0 = 32'd6; bus.b0 = 32'd7; end
      if (j == 1) begin bus.a1 = 32'd8; bus.b1 = 32'd9; end
      if (j == 3) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
    end
    repeat (3) step();
    n_tests++;
    if ({bus.mul_op_start, bus.gnt0, bus.gnt1} !== 3'b000) begin
      n_fail++;
      $display("FAIL b2b_quiet: got start/gnt0/gnt1=%b want 000", {bus.mul_op_start, bus.gnt0, bus.gnt1});
    end
  endtask

  task automatic test_abort();
    bit ok;
    never_done = 1'b1;
    bus.a1 = 32'd11; bus.b1 = 32'd13; bus.req1 = 1'b1;
    step();
    n_tests++;
    if ({bus.gnt1, bus.mul_op_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_grant: got gnt1/start=%b want 11", {bus.gnt1, bus.mul_op_start});
    end
    bus.a0 = 32'd4; bus.b0 = 32'd5; bus.req0 = 1'b1;
    repeat (3) step();
    bus.req1 = 1'b0;
    step();
    n_tests++;
    if ({bus.mul_op_clear, bus.gnt1, bus.done1, bus.err_timeout} !== 4'b1000) begin
      n_fail++;
      $display("FAIL abort_clear: got clear/gnt1/done1/err=%b want 1000",
               {bus.mul_op_clear, bus.gnt1, bus.done1, bus.err_timeout});
    end
    never_done = 1'b0;
    sb.push_back('{id: 1'b0, prod: 64'd20});
    step();
    n_tests++;
    if (bus.done1 !== 1'b0 || bus.result1 !== 64'd72) begin
      n_fail++;
      $display("FAIL abort_result1: got done1=%b result1=%0d want 0 72", bus.done1, bus.result1);
    end
    step();
    n_tests++;
    if ({bus.gnt0, bus.mul_op_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL abort_next: got gnt0/start=%b want 11", {bus.gnt0, bus.mul_op_start});
    end
    wait_done(1'b0, ok);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL abort_next_done: got no done0 within 40 cycles want done0");
    end
    bus.req0 = 1'b0;
    repeat (2) step();
  endtask

  task automatic test_timeout();
    never_done = 1'b1;
    bus.a0 = 32'd3; bus.b0 = 32'd3; bus.req0 = 1'b1;
    step();
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++;
      if ({bus.err_timeout, bus.mul_op_clear} !== 2'b00) begin
        n_fail++;
        $display("FAIL timeout_wait%0d: got err/clear=%b want 00", i, {bus.err_timeout, bus.mul_op_clear});
      end
    end
    step();
    n_tests++;
    if ({bus.err_timeout, bus.mul_op_clear, bus.done0, bus.gnt0} !== 4'b1100) begin
      n_fail++;
      $display("FAIL timeout_abort: got err/clear/done0/gnt0=%b want 1100",
               {bus.err_timeout, bus.mul_op_clear, bus.done0, bus.gnt0});
    end
    bus.req0 = 1'b0;
    step();
    step();
    n_tests++;
    if ({bus.err_timeout, bus.mul_op_start, bus.gnt0} !== 3'b000) begin
      n_fail++;
      $display("FAIL timeout_idle: got err/start/gnt0=%b want 000", {bus.err_timeout, bus.mul_op_start, bus.gnt0});
    end
    never_done = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok;
    logic [327:0] outs;
    lat = 5;
    bus.a0 = 32'd12; bus.b0 = 32'd12; bus.req0 = 1'b1;
    repeat (3) step();
    #2 reset_n = 1'b0;
    #1;
    outs = {bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.err_timeout, bus.mul_op_start,
            bus.mul_op_clear, bus.mul_a, bus.mul_b, bus.result0, bus.result1};
    n_tests++;
    if (outs !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h want 0", outs);
    end
    bus.req0 = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    bus.a0 = 32'hFFFF_FFFC; bus.b0 = 32'd25; bus.req0 = 1'b1;
    sb.push_back('{id: 1'b0, prod: 64'hFFFF_FFFF_FFFF_FF9C});
    step();
    n_tests++;
    if ({bus.gnt0, bus.mul_op_start} !== 2'b11) begin
      n_fail++;
      $display("FAIL async_regrant: got gnt0/start=%b want 11", {bus.gnt0, bus.mul_op_start});
    end
    wait_done(1'b0, ok);
    n_tests++;
    if (!ok || bus.result0 !== 64'hFFFF_FFFF_FFFF_FF9C) begin
      n_fail++;
      $display("FAIL async_done: got ok=%0d result0=%h want 1 ffffffffffffff9c", ok, bus.result0);
    end
    bus.req0 = 1'b0;
    repeat (2) step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie_after_reset();
    test_back_to_back();
    test_abort();
    test_timeout();
    test_async_reset();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending results want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
